sobel_ctrl: RTL and testbench



---
 rtl/sobel_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sobel_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_ctrl.sv
// sobel_ctrl -- streaming 3x3 Sobel edge detector.
//
// Accepts an IMG_W x IMG_H 8-bit grayscale frame in raster order, one pixel
// per pi_flag strobe, and emits one RGB565 black/white pixel per interior
// 3x3 window ((IMG_W-2)*(IMG_H-2) outputs per frame). The output colour is
// EDGE_COLOR when |Gx|+|Gy| >= THRESHOLD, BACK_COLOR otherwise.
//
// Ports:
//   sys_clk    in   1   clock
//   sys_rst_n  in   1   asynchronous active-low reset
//   pi_flag    in   1   input strobe, pi_data valid this cycle
//   pi_data    in   8   grayscale pixel
//   po_flag    out  1   output strobe, po_data valid this cycle
//   po_data    out  16  RGB565 edge/background pixel (held when po_flag=0)
//
// Latency: po_flag rises 3 cycles after the pi_flag of the pixel that
// completes a window, regardless of gaps between input strobes.

module sobel_ctrl #(
  parameter int          IMG_W      = 100,
  parameter int          IMG_H      = 100,
  parameter logic [10:0] THRESHOLD  = 11'd100,
  parameter logic [15:0] EDGE_COLOR = 16'h0000,
  parameter logic [15:0] BACK_COLOR = 16'hFFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pi_flag,
  input  logic [7:0]  pi_data,
  output logic        po_flag,
  output logic [15:0] po_data
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // ---------------------------------------------------------------------
  // Raster position counters
  // ---------------------------------------------------------------------
  logic [CW-1:0] col_cnt_reg, col_cnt_next;
  logic [RW-1:0] row_cnt_reg, row_cnt_next;

  always_comb begin
    col_cnt_next = col_cnt_reg;
    row_cnt_next = row_cnt_reg;
    if (pi_flag) begin
      if (col_cnt_reg == CW'(IMG_W - 1)) begin
        col_cnt_next = '0;
        if (row_cnt_reg == RW'(IMG_H - 1))
          row_cnt_next = '0;
        else
          row_cnt_next = row_cnt_reg + RW'(1);
      end else begin
        col_cnt_next = col_cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else begin
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Line buffers (synchronous-read RAMs)
  // The read port is addressed with the column of the *next* pixel, so the
  // registered read data for column c is already waiting when pixel c
  // arrives. Column c is only rewritten by pixel c itself, so the
  // prefetched word stays current however long the input pauses.
  // lb2[c] takes the old lb1[c], which is exactly the prefetched word.
  // ---------------------------------------------------------------------
  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic [7:0] lb1_rd_reg;
  logic [7:0] lb2_rd_reg;

  always_ff @(posedge sys_clk) begin
    if (pi_flag) begin
      lb1[col_cnt_reg] <= pi_data;
      lb2[col_cnt_reg] <= lb1_rd_reg;
    end
    lb1_rd_reg <= lb1[col_cnt_next];
    lb2_rd_reg <= lb2[col_cnt_next];
  end

  // ---------------------------------------------------------------------
  // 3x3 window: win_reg[row][col], row 0 = oldest line, col 2 = newest
  // ---------------------------------------------------------------------
  logic [7:0] win_reg [3][3];
  logic [7:0] col_in  [3];
  logic       win_vld_reg;
  logic       win_ok;

  assign col_in[0] = lb2_rd_reg;
  assign col_in[1] = lb1_rd_reg;
  assign col_in[2] = pi_data;

  // Requiring col >= 2 keeps windows from straddling two rows; requiring
  // row >= 2 keeps stale line-buffer data from the last frame out.
  assign win_ok = (row_cnt_reg >= RW'(2)) && (col_cnt_reg >= CW'(2));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_reg[i][j] <= '0;
      win_vld_reg <= 1'b0;
    end else begin
      if (pi_flag) begin
        for (int i = 0; i < 3; i++) begin
          win_reg[i][0] <= win_reg[i][1];
          win_reg[i][1] <= win_reg[i][2];
          win_reg[i][2] <= col_in[i];
        end
      end
      win_vld_reg <= pi_flag && win_ok;
    end
  end

  // ---------------------------------------------------------------------
  // Gradient stage
  // Each weighted sum is at most 1020, so 10-bit unsigned sums and an
  // 11-bit signed difference are exact.
  // ---------------------------------------------------------------------
  logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_next, gy_next;
  logic signed [10:0] gx_reg, gy_reg;
  logic               grad_vld_reg;

  assign gx_pos = {2'b00, win_reg[0][2]} + {1'b0, win_reg[1][2], 1'b0} + {2'b00, win_reg[2][2]};
  assign gx_neg = {2'b00, win_reg[0][0]} + {1'b0, win_reg[1][0], 1'b0} + {2'b00, win_reg[2][0]};
  assign gy_pos = {2'b00, win_reg[2][0]} + {1'b0, win_reg[2][1], 1'b0} + {2'b00, win_reg[2][2]};
  assign gy_neg = {2'b00, win_reg[0][0]} + {1'b0, win_reg[0][1], 1'b0} + {2'b00, win_reg[0][2]};

  assign gx_next = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy_next = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gx_reg       <= '0;
      gy_reg       <= '0;
      grad_vld_reg <= 1'b0;
    end else begin
      gx_reg       <= gx_next;
      gy_reg       <= gy_next;
      grad_vld_reg <= win_vld_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Magnitude, threshold and output register
  // |Gx|,|Gy| <= 1020 so the 11-bit sum (max 2040) cannot overflow.
  // ---------------------------------------------------------------------
  logic [10:0] gx_abs, gy_abs, mag;

  assign gx_abs = gx_reg[10] ? 11'(-gx_reg) : 11'(gx_reg);
  assign gy_abs = gy_reg[10] ? 11'(-gy_reg) : 11'(gy_reg);
  assign mag    = gx_abs + gy_abs;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_flag <= 1'b0;
      po_data <= 16'h0000;
    end else begin
      po_flag <= grad_vld_reg;
      if (grad_vld_reg)
        po_data <= (mag >= THRESHOLD) ? EDGE_COLOR : BACK_COLOR;
    end
  end

endmodule

// File: tb/tb_sobel_ctrl.sv
// Self-checking bench for sobel_ctrl: drives edge, uniform and random
// frames (back-to-back and with random gaps) and compares every output
// pixel and its arrival cycle against a direct Sobel model of the frame.

module tb_sobel_ctrl;

  localparam int W = 100;
  localparam int H = 100;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        pi_flag   = 1'b0;
  logic [7:0]  pi_data   = 8'h00;
  logic        po_flag;
  logic [15:0] po_data;

  sobel_ctrl #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pi_flag   (pi_flag),
    .pi_data   (pi_data),
    .po_flag   (po_flag),
    .po_data   (po_data)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: the frame as it is being sent, plus a scoreboard of
  // expected output pixels and the cycle each must appear in.
  int          img [H][W];
  int          exp_data_q [$];
  int          exp_cyc_q  [$];
  int          pulse_cnt = 0;
  int          edge_cnt  = 0;
  logic [15:0] last_data = 16'h0000;

  // Output for the window whose bottom-right corner is pixel (r,c).
  function automatic int sobel_ref(input int r, input int c);
    int gx, gy, mag;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag >= 100) ? 32'h0000 : 32'hFFFF;
  endfunction

  always @(negedge sys_clk) begin
    int ed, ec;
    if (sys_rst_n) begin
      if (po_flag) begin
        pulse_cnt++;
        if (po_data == 16'h0000) edge_cnt++;
        if (exp_data_q.size() == 0) begin
          check("unexpected_po_flag", 1, 0);
        end else begin
          ed = exp_data_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("po_data", po_data, ed);
          check("po_cycle", cyc, ec);
        end
        last_data = po_data;
      end else begin
        check("po_data_hold", po_data, last_data);
      end
    end
  end

  // kind: 0 = uniform 50, 1 = vertical edge at column 50, 2 = random.
  // Leaves pi_flag high on the last pixel so frames can run back-to-back.
  task automatic send_pixels(input int kind, input int npix, input int gap_max);
    for (int i = 0; i < npix; i++) begin
      int r, c, v, g;
      r = i / W;
      c = i % W;
      case (kind)
        0:       v = 50;
        1:       v = (c >= 50) ? 255 : 0;
        default: v = int'($urandom_range(255));
      endcase
      img[r][c] = v;
      @(posedge sys_clk); #1;
      pi_flag = 1'b1;
      pi_data = 8'(v);
      if (r >= 2 && c >= 2) begin
        exp_data_q.push_back(sobel_ref(r, c));
        exp_cyc_q.push_back(cyc + 3);
      end
      g = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
      for (int k = 0; k < g; k++) begin
        @(posedge sys_clk); #1;
        pi_flag = 1'b0;
      end
    end
  endtask

  task automatic stop_input();
    @(posedge sys_clk); #1;
    pi_flag = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && exp_data_q.size() != 0; k++) @(posedge sys_clk);
    @(negedge sys_clk);
    check(tag, exp_data_q.size(), 0);
    exp_data_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_po_flag", po_flag, 0);
    check("reset_po_data", po_data, 16'h0000);
    #3 sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    // Two edge frames back-to-back: second must not see stale data.
    pulse_cnt = 0; edge_cnt = 0;
    send_pixels(1, W*H, 0);
    send_pixels(1, W*H, 0);
    stop_input();
    drain("b2b_drain");
    check("b2b_pulse_count", pulse_cnt, 2*(W-2)*(H-2));
    check("b2b_edge_count", edge_cnt, 2*2*(H-2));
    $display("phase b2b_edge: pulses=%0d edges=%0d", pulse_cnt, edge_cnt);

    // Edge frame with random 0..5 idle cycles between strobes.
    pulse_cnt = 0; edge_cnt = 0;
    send_pixels(1, W*H, 5);
    stop_input();
    drain("gap_drain");
    check("gap_pulse_count", pulse_cnt, (W-2)*(H-2));
    check("gap_edge_count", edge_cnt, 2*(H-2));
    $display("phase gapped_edge: pulses=%0d edges=%0d", pulse_cnt, edge_cnt);

    // Random partial frame, then an asynchronous reset mid-cycle.
    send_pixels(2, 5000, 0);
    stop_input();
    #2 sys_rst_n = 1'b0;
    exp_data_q.delete();
    exp_cyc_q.delete();
    last_data = 16'h0000;
    #1;
    check("midrst_po_flag", po_flag, 0);
    check("midrst_po_data", po_data, 16'h0000);
    repeat (2) @(posedge sys_clk);
    #1;
    check("midrst_hold_po_flag", po_flag, 0);
    check("midrst_hold_po_data", po_data, 16'h0000);
    #2 sys_rst_n = 1'b1;
    $display("phase reset_mid_frame: reset applied after 5000 pixels");

    // Full uniform frame after reset: all background.
    pulse_cnt = 0; edge_cnt = 0;
    send_pixels(0, W*H, 0);
    stop_input();
    drain("uni_drain");
    check("uni_pulse_count", pulse_cnt, (W-2)*(H-2));
    check("uni_edge_count", edge_cnt, 0);
    $display("phase uniform: pulses=%0d edges=%0d", pulse_cnt, edge_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
